count_tracker: RTL and testbench

COUNT_TRACKER -- requirements
Module: count_tracker

---
 rtl/count_tracker_pkg.sv | 20 ++
 rtl/count_tracker_sat_counter.sv | 28 ++
 rtl/count_tracker.sv | 168 ++++++++++++++++
 tb/tb_count_tracker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_tracker_pkg.sv
// count_tracker_pkg: shared types, widths and the sample prediction helper
// used by the count tracker and its sub-modules.
package count_tracker_pkg;

  localparam int CNT_W  = 4;
  localparam int ERRC_W = 8;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Next expected counter value: +1 when counting up, -1 when counting down.
  function automatic logic [CNT_W-1:0] predict(input logic [CNT_W-1:0] last,
                                               input logic             dir);
    return dir ? (last - CNT_W'(1)) : (last + CNT_W'(1));
  endfunction

endpackage

// File: rtl/count_tracker_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Asynchronous reset, synchronous clear.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  // Count increments, holding once every bit is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/count_tracker.sv
// count_tracker: follows a sampled 4-bit counter, locks after LOCK_CNT
// consecutive correct predictions and drops lock after LOSS_CNT consecutive
// mispredictions. Defining COUNT_TRACKER_STATS_EN adds the good_cnt output.
module count_tracker
  import count_tracker_pkg::*;
#(
  parameter int LOCK_CNT = 2,
  parameter int LOSS_CNT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              dir,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  in_data,
  output logic              locked,
  output logic              err,
  output logic              wrap,
  output logic [ERRC_W-1:0] err_cnt,
  output logic [CNT_W-1:0]  last
`ifdef COUNT_TRACKER_STATS_EN
  ,
  output logic [15:0]       good_cnt
`endif
);

  // Run counters only ever hold values up to the larger threshold.
  localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int RUN_W   = (RUN_MAX < 2) ? 1 : $clog2(RUN_MAX + 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] last_reg, last_next;
  logic [RUN_W-1:0] good_run_reg, good_run_next;
  logic [RUN_W-1:0] bad_run_reg, bad_run_next;
  logic             err_reg, err_next;
  logic             wrap_reg, wrap_next;
  logic             ready_reg;

  logic             accept;
  logic             match;
  logic             crossing;
  logic [RUN_W-1:0] good_run_inc;
  logic [RUN_W-1:0] bad_run_inc;

  // Clear gates readiness combinationally so it always wins over a sample.
  assign in_ready     = ready_reg && !clear;
  assign accept       = in_valid && in_ready;
  assign match        = (in_data == predict(last_reg, dir));
  assign crossing     = dir ? (in_data == '1) : (in_data == '0);
  assign good_run_inc = good_run_reg + RUN_W'(1);
  assign bad_run_inc  = bad_run_reg + RUN_W'(1);

  // Readiness: low through reset, the clear cycle and the cycle after clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= !clear;
    end
  end

  // Tracking state register; pulses and last sample update with the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= SEARCH;
      last_reg     <= '0;
      good_run_reg <= '0;
      bad_run_reg  <= '0;
      err_reg      <= 1'b0;
      wrap_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      good_run_reg <= good_run_next;
      bad_run_reg  <= bad_run_next;
      err_reg      <= err_next;
      wrap_reg     <= wrap_next;
    end
  end

  // Next-state and pulse decode for an accepted sample.
  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    good_run_next = good_run_reg;
    bad_run_next  = bad_run_reg;
    err_next      = 1'b0;
    wrap_next     = 1'b0;
    if (clear) begin
      state_next    = SEARCH;
      last_next     = '0;
      good_run_next = '0;
      bad_run_next  = '0;
    end else if (accept) begin
      last_next = in_data;
      case (state_reg)
        SEARCH: begin
          good_run_next = '0;
          bad_run_next  = '0;
          state_next    = CHECK;
        end
        CHECK: begin
          if (match) begin
            wrap_next = crossing;
            if (good_run_inc == RUN_W'(LOCK_CNT)) begin
              state_next    = LOCKED;
              good_run_next = '0;
              bad_run_next  = '0;
            end else begin
              good_run_next = good_run_inc;
            end
          end else begin
            err_next      = 1'b1;
            good_run_next = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            wrap_next    = crossing;
            bad_run_next = '0;
          end else begin
            err_next = 1'b1;
            if (bad_run_inc == RUN_W'(LOSS_CNT)) begin
              state_next    = SEARCH;
              good_run_next = '0;
              bad_run_next  = '0;
            end else begin
              bad_run_next = bad_run_inc;
            end
          end
        end
        default: begin
          state_next = SEARCH;
        end
      endcase
    end
  end

  assign locked = (state_reg == LOCKED);
  assign err    = err_reg;
  assign wrap   = wrap_reg;
  assign last   = last_reg;

  sat_counter #(.WIDTH(ERRC_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (err_next),
    .count (err_cnt)
  );

`ifdef COUNT_TRACKER_STATS_EN
  logic good_hit;

  // Correct samples seen while already locked.
  assign good_hit = accept && (state_reg == LOCKED) && match;

  sat_counter #(.WIDTH(16)) u_good_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (good_hit),
    .count (good_cnt)
  );
`endif

endmodule

// File: tb/tb_count_tracker.sv
// tb_count_tracker: directed stimulus with a scoreboard queue; a monitor
// compares DUT outputs one cycle after each accepted sample.
module tb_count_tracker;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       dir;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       locked;
  logic       err;
  logic       wrap;
  logic [7:0] err_cnt;
  logic [3:0] last;
`ifdef COUNT_TRACKER_STATS_EN
  logic [15:0] good_cnt;
`endif

  typedef struct {
    logic [3:0] data;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [7:0] err_cnt;
    logic [3:0] last;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  count_tracker #(.LOCK_CNT(2), .LOSS_CNT(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .dir      (dir),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .locked   (locked),
    .err      (err),
    .wrap     (wrap),
    .err_cnt  (err_cnt),
    .last     (last)
`ifdef COUNT_TRACKER_STATS_EN
    ,
    .good_cnt (good_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic dr, input logic l,
                      input logic e, input logic w, input logic [7:0] ec);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    dir      = dr;
    sb_q.push_back('{d, l, e, w, ec, d});
    #1 check1("ready_at_send", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_clear(input logic [3:0] junk);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = junk;
    #1 check1("ready_in_clear", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check1("clear_locked", {31'd0, locked}, 32'd0);
    check1("clear_last", {28'd0, last}, 32'd0);
    check1("clear_err_cnt", {24'd0, err_cnt}, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    #1 check1("ready_after_clear", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check1("ready_back", {31'd0, in_ready}, 32'd1);
    check1("clear_sample_ignored", {28'd0, last}, 32'd0);
  endtask

  // Monitor: every accepted sample produces one checked response a cycle later.
  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) begin
      #1;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_accept: got data %0h accepted, expected no transaction", in_data);
      end else begin
        mon_x = sb_q.pop_front();
        n_txn++;
        if (locked !== mon_x.locked || err !== mon_x.err || wrap !== mon_x.wrap ||
            err_cnt !== mon_x.err_cnt || last !== mon_x.last) begin
          n_fail++;
          $display("FAIL txn%0d data=%h: got locked=%b err=%b wrap=%b err_cnt=%h last=%h expected locked=%b err=%b wrap=%b err_cnt=%h last=%h",
                   n_txn, mon_x.data, locked, err, wrap, err_cnt, last,
                   mon_x.locked, mon_x.err, mon_x.wrap, mon_x.err_cnt, mon_x.last);
        end else begin
          $display("txn %0d data=%h locked=%b err=%b wrap=%b err_cnt=%h last=%h",
                   n_txn, mon_x.data, locked, err, wrap, err_cnt, last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    clear    = 1'b0;
    dir      = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    #1 reset = 1'b1;
    #1;
    // Reset values before any clock edge.
    check1("rst_ready", {31'd0, in_ready}, 32'd0);
    check1("rst_locked", {31'd0, locked}, 32'd0);
    check1("rst_err", {31'd0, err}, 32'd0);
    check1("rst_wrap", {31'd0, wrap}, 32'd0);
    check1("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check1("rst_last", {28'd0, last}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check1("ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 check1("ready_after_edge", {31'd0, in_ready}, 32'd1);

    // Up stream locks after the second correct sample.
    send(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send(4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send(4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send(4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int v = 7; v <= 15; v++) send(4'(v), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send(4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    send(4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check1("idle_err", {31'd0, err}, 32'd0);
    check1("idle_wrap", {31'd0, wrap}, 32'd0);

    // Clear with a valid sample present, then down-count loss of lock.
    do_clear(4'h7);
    send(4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send(4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send(4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    send(4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    send(4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01);
    send(4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 8'h02);
    send(4'h9, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03);
    // Down wrap in CHECK, relock, then a direction change.
    send(4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
    send(4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03);
    send(4'hE, 1'b1, 1'b1, 1'b0, 1'b0, 8'h03);
    send(4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
    // Bad run resets on a correct sample; err never coincides with wrap.
    send(4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h04);
    send(4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
    send(4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 8'h05);
    send(4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 8'h06);
    send(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 8'h06);
    send(4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07);

    // Saturation: 300 mismatches in CHECK.
    do_clear(4'h2);
    send(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 300; i++) send(4'h5, 1'b0, 1'b0, 1'b1, 1'b0, (i > 255) ? 8'hFF : 8'(i));
    send(4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
    send(4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);

    // Asynchronous reset while locked with a sample in flight.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'h8;
    #3 reset = 1'b1;
    #1;
    check1("mid_rst_locked", {31'd0, locked}, 32'd0);
    check1("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check1("mid_rst_last", {28'd0, last}, 32'd0);
    check1("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check1("mid_rst_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check1("in_flight_discarded", {28'd0, last}, 32'd0);
    check1("mid_rst_ready_high", {31'd0, in_ready}, 32'd1);
    send(4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send(4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    #2;
    check1("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
